// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: sequencer state encoding and stage indices
// for the stall/flush vectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERR
    } mem_state_t;

    localparam int unsigned STG_F = 0;
    localparam int unsigned STG_D = 1;
    localparam int unsigned STG_E = 2;
    localparam int unsigned STG_M = 3;
    localparam int unsigned STG_W = 4;
    localparam int unsigned N_STG = 5;

endpackage

// File: rtl/hazard_det.sv
// Load-use hazard detector: a load in EX whose destination feeds a source
// register of the valid instruction in ID.
module hazard_det (
    input  logic       e_valid,
    input  logic       e_is_load,
    input  logic [4:0] e_reg_d,
    input  logic       d_valid,
    input  logic [4:0] d_reg_s1,
    input  logic [4:0] d_reg_s2,
    output logic       load_use
);

    always_comb begin
        load_use = e_valid && e_is_load && (e_reg_d != 5'd0) && d_valid &&
                   ((e_reg_d == d_reg_s1) || (e_reg_d == d_reg_s2));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall/flush generation and MEM-stage bus
// access sequencing with a timeout into a sticky error state.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        F_BUSY,
    input  logic        D_VALID,
    input  logic [4:0]  D_REG_S1,
    input  logic [4:0]  D_REG_S2,
    input  logic        E_VALID,
    input  logic        E_IS_LOAD,
    input  logic [4:0]  E_REG_D,
    input  logic        E_JMP_DO,
    input  logic        M_MEM_REQ,
    input  logic        MEM_DONE,
    output logic        STALL_F,
    output logic        STALL_D,
    output logic        STALL_E,
    output logic        STALL_M,
    output logic        STALL_W,
    output logic        FLUSH_D,
    output logic        FLUSH_E,
    output logic        MEM_ISSUE,
    output logic        BUS_ERR,
    output logic [31:0] STALL_CYCLES
);

    mem_state_t           state, state_next;
    logic [TIMEOUT_W-1:0] cnt, cnt_next;
    logic                 err_q;
    logic [31:0]          stall_cnt;
    logic [N_STG-1:0]     stall, flush;
    logic                 issue;
    logic                 load_use;

    hazard_det u_hazard (
        .e_valid   (E_VALID),
        .e_is_load (E_IS_LOAD),
        .e_reg_d   (E_REG_D),
        .d_valid   (D_VALID),
        .d_reg_s1  (D_REG_S1),
        .d_reg_s2  (D_REG_S2),
        .load_use  (load_use)
    );

    always_comb begin
        stall      = '0;
        flush      = '0;
        issue      = 1'b0;
        state_next = state;
        cnt_next   = cnt;
        if (RST) begin
            flush[STG_D] = 1'b1;
            flush[STG_E] = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (M_MEM_REQ) begin
                        stall      = '1;
                        issue      = 1'b1;
                        state_next = ST_MEM_WAIT;
                        cnt_next   = '0;
                    end else if (E_JMP_DO) begin
                        // wrong-path ID instruction: its hazard is irrelevant
                        flush[STG_D] = 1'b1;
                        flush[STG_E] = 1'b1;
                        stall[STG_F] = F_BUSY;
                    end else if (load_use) begin
                        stall[STG_F] = 1'b1;
                        stall[STG_D] = 1'b1;
                        flush[STG_E] = 1'b1;
                    end else if (F_BUSY) begin
                        stall[STG_F] = 1'b1;
                        flush[STG_D] = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (MEM_DONE) begin
                        state_next = ST_RUN;
                    end else begin
                        stall = '1;
                        if (cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
                            state_next = ST_ERR;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    stall = '1;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_RUN;
            cnt       <= '0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err_q <= err_q || (state_next == ST_ERR);
            if (stall[STG_M] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign STALL_F      = stall[STG_F];
    assign STALL_D      = stall[STG_D];
    assign STALL_E      = stall[STG_E];
    assign STALL_M      = stall[STG_M];
    assign STALL_W      = stall[STG_W];
    assign FLUSH_D      = flush[STG_D];
    assign FLUSH_E      = flush[STG_E];
    assign MEM_ISSUE    = issue;
    assign BUS_ERR      = err_q;
    assign STALL_CYCLES = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; outputs packed as
// {STALL_F,D,E,M,W, FLUSH_D,E, MEM_ISSUE, BUS_ERR}.
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        F_BUSY, D_VALID, E_VALID, E_IS_LOAD, E_JMP_DO, M_MEM_REQ, MEM_DONE;
    logic [4:0]  D_REG_S1, D_REG_S2, E_REG_D;
    logic        STALL_F, STALL_D, STALL_E, STALL_M, STALL_W;
    logic        FLUSH_D, FLUSH_E, MEM_ISSUE, BUS_ERR;
    logic [31:0] STALL_CYCLES;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    always #5 CLK = ~CLK;

    pipe_ctrl #(.TIMEOUT_W(8), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .F_BUSY(F_BUSY), .D_VALID(D_VALID),
        .D_REG_S1(D_REG_S1), .D_REG_S2(D_REG_S2), .E_VALID(E_VALID),
        .E_IS_LOAD(E_IS_LOAD), .E_REG_D(E_REG_D), .E_JMP_DO(E_JMP_DO),
        .M_MEM_REQ(M_MEM_REQ), .MEM_DONE(MEM_DONE),
        .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E),
        .STALL_M(STALL_M), .STALL_W(STALL_W), .FLUSH_D(FLUSH_D),
        .FLUSH_E(FLUSH_E), .MEM_ISSUE(MEM_ISSUE), .BUS_ERR(BUS_ERR),
        .STALL_CYCLES(STALL_CYCLES)
    );

    function automatic logic [8:0] outs();
        return {STALL_F, STALL_D, STALL_E, STALL_M, STALL_W,
                FLUSH_D, FLUSH_E, MEM_ISSUE, BUS_ERR};
    endfunction

    task automatic idle_inputs();
        F_BUSY = 0; D_VALID = 0; E_VALID = 0; E_IS_LOAD = 0; E_JMP_DO = 0;
        M_MEM_REQ = 0; MEM_DONE = 0; D_REG_S1 = 0; D_REG_S2 = 0; E_REG_D = 0;
    endtask

    // advance one cycle; inputs change 1 time unit after the edge, checks at +2
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1;
        #2;
        vectors++;
        if (outs() !== 9'b00000_11_0_0)
            $display("FAIL reset_outs got=%b exp=%b", outs(), 9'b00000_11_0_0);
        if (outs() !== 9'b00000_11_0_0) errs++;
        tick();
        #1;
        vectors++;
        if (STALL_CYCLES !== 32'd0 || BUS_ERR !== 1'b0) begin
            $display("FAIL reset_regs cycles=%0d err=%b exp 0/0", STALL_CYCLES, BUS_ERR);
            errs++;
        end
        tick();
        RST = 0;
        #1;
        vectors++;
        if (outs() !== 9'b0) begin
            $display("FAIL idle_outs got=%b exp=%b", outs(), 9'b0);
            errs++;
        end
    endtask

    task automatic test_fetch_miss();
        tick();
        idle_inputs();
        F_BUSY = 1;
        #1;
        vectors++;
        if (outs() !== 9'b10000_10_0_0) begin
            $display("FAIL fetch_miss got=%b exp=%b", outs(), 9'b10000_10_0_0);
            errs++;
        end
    endtask

    task automatic test_load_use();
        tick();
        idle_inputs();
        E_VALID = 1; E_IS_LOAD = 1; E_REG_D = 5; D_VALID = 1; D_REG_S1 = 3; D_REG_S2 = 5;
        #1;
        vectors++;
        if (outs() !== 9'b11000_01_0_0) begin
            $display("FAIL load_use_s2 got=%b exp=%b", outs(), 9'b11000_01_0_0);
            errs++;
        end
        tick();
        E_REG_D = 0; D_REG_S1 = 0; D_REG_S2 = 0;
        #1;
        vectors++;
        if (outs() !== 9'b0) begin
            $display("FAIL load_use_x0 got=%b exp=%b", outs(), 9'b0);
            errs++;
        end
        tick();
        E_REG_D = 9; D_REG_S1 = 9; D_REG_S2 = 2; F_BUSY = 1;
        #1;
        vectors++;
        if (outs() !== 9'b11000_01_0_0) begin
            $display("FAIL load_use_fbusy got=%b exp=%b", outs(), 9'b11000_01_0_0);
            errs++;
        end
        tick();
        E_IS_LOAD = 0; F_BUSY = 0;
        #1;
        vectors++;
        if (outs() !== 9'b0) begin
            $display("FAIL not_load got=%b exp=%b", outs(), 9'b0);
            errs++;
        end
    endtask

    task automatic test_branch_hazard();
        tick();
        idle_inputs();
        E_VALID = 1; E_IS_LOAD = 1; E_REG_D = 5; D_VALID = 1; D_REG_S2 = 5; E_JMP_DO = 1;
        #1;
        vectors++;
        if (outs() !== 9'b00000_11_0_0) begin
            $display("FAIL branch_hazard got=%b exp=%b", outs(), 9'b00000_11_0_0);
            errs++;
        end
        tick();
        F_BUSY = 1;
        #1;
        vectors++;
        if (outs() !== 9'b10000_11_0_0) begin
            $display("FAIL branch_fbusy got=%b exp=%b", outs(), 9'b10000_11_0_0);
            errs++;
        end
    endtask

    task automatic test_mem_access();
        logic [31:0] sc0;
        logic [8:0]  exp_wait [3];
        tick();
        idle_inputs();
        M_MEM_REQ = 1; E_JMP_DO = 1;
        #1;
        sc0 = STALL_CYCLES;
        vectors++;
        if (outs() !== 9'b11111_00_1_0) begin
            $display("FAIL mem_issue got=%b exp=%b", outs(), 9'b11111_00_1_0);
            errs++;
        end
        exp_wait = '{9'b11111_00_0_0, 9'b11111_00_0_0, 9'b00000_00_0_0};
        for (int i = 0; i < 3; i++) begin
            tick();
            MEM_DONE = (i == 2);
            #1;
            vectors++;
            if (outs() !== exp_wait[i]) begin
                $display("FAIL mem_wait_c%0d got=%b exp=%b", i + 1, outs(), exp_wait[i]);
                errs++;
            end
        end
        tick();
        MEM_DONE = 0; M_MEM_REQ = 1; E_JMP_DO = 0;
        #1;
        vectors++;
        if (outs() !== 9'b11111_00_1_0) begin
            $display("FAIL mem_b2b_issue got=%b exp=%b", outs(), 9'b11111_00_1_0);
            errs++;
        end
        vectors++;
        if (STALL_CYCLES !== sc0 + 32'd3) begin
            $display("FAIL stall_cycles got=%0d exp=%0d", STALL_CYCLES, sc0 + 32'd3);
            errs++;
        end
        tick();
        MEM_DONE = 1;
        #1;
        vectors++;
        if (outs() !== 9'b0) begin
            $display("FAIL mem_b2b_done got=%b exp=%b", outs(), 9'b0);
            errs++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mem_wait();
        idle_inputs();
        M_MEM_REQ = 1;
        tick();
        tick();
        RST = 1;
        #1;
        vectors++;
        if (outs() !== 9'b00000_11_0_0) begin
            $display("FAIL rst_in_wait got=%b exp=%b", outs(), 9'b00000_11_0_0);
            errs++;
        end
        tick();
        RST = 0; M_MEM_REQ = 0; MEM_DONE = 1;
        #1;
        vectors++;
        if (outs() !== 9'b0 || STALL_CYCLES !== 32'd0) begin
            $display("FAIL late_done got=%b cycles=%0d exp=%b cycles=0", outs(), STALL_CYCLES, 9'b0);
            errs++;
        end
        tick();
        MEM_DONE = 0; M_MEM_REQ = 1;
        #1;
        vectors++;
        if (outs() !== 9'b11111_00_1_0) begin
            $display("FAIL run_after_rst got=%b exp=%b", outs(), 9'b11111_00_1_0);
            errs++;
        end
        tick();
        MEM_DONE = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [8:0] expv;
        idle_inputs();
        M_MEM_REQ = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) begin
                MEM_DONE = 1; F_BUSY = 1; E_JMP_DO = 1;
            end
            #1;
            expv = (c >= 5) ? 9'b11111_00_0_1 : 9'b11111_00_0_0;
            vectors++;
            if (outs() !== expv) begin
                $display("FAIL timeout_c%0d got=%b exp=%b", c, outs(), expv);
                errs++;
            end
        end
        tick();
        idle_inputs();
        RST = 1;
        tick();
        RST = 0;
        #1;
        vectors++;
        if (outs() !== 9'b0) begin
            $display("FAIL err_cleared got=%b exp=%b", outs(), 9'b0);
            errs++;
        end
    endtask

    initial begin
        test_reset();
        test_fetch_miss();
        test_load_use();
        test_branch_hazard();
        test_mem_access();
        test_reset_mem_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
